// File: rtl/demuxer8_tdm.sv
// rtl/demuxer8_tdm.sv - serial-to-parallel TDM demultiplexer, 8 slots per frame
//
// Purpose: collects serial bits into an 8-bit frame, either by an internal
// slot counter (auto mode) or by an explicit slot address (addressed mode),
// and presents completed frames on a valid/ready output with sticky overflow.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   d         serial data bit
//   d_valid   d is sampled this cycle
//   sync      frame start in auto mode (slot counter back to slot 0)
//   sel_mode  0 = auto (slot counter), 1 = addressed (slot from sel)
//   sel       target slot in addressed mode
//   q         assembled frame
//   q_valid   q holds an unconsumed frame
//   q_ready   consumer takes q when q_valid && q_ready
//   overflow  sticky, set when a completed frame had to be dropped

module demuxer8_tdm #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d,
   input  logic       d_valid,
   input  logic       sync,
   input  logic       sel_mode,
   input  logic [2:0] sel,
   output logic [7:0] q,
   output logic       q_valid,
   input  logic       q_ready,
   output logic       overflow
);

   logic [7:0] asm_reg;
   logic [7:0] asm_nxt;
   logic [2:0] cnt;
   logic [2:0] cnt_eff;
   logic [2:0] cnt_nxt;
   logic [2:0] slot;
   logic [2:0] idx;
   logic       prev_mode;
   logic       complete;

   always_comb begin
      // A mode switch restarts slot counting; the assembly register is kept.
      cnt_eff = (sel_mode != prev_mode) ? 3'd0 : cnt;

      if (sel_mode)
         slot = sel;
      else if (sync)
         slot = 3'd0;
      else
         slot = cnt_eff;

      // Bit-order reversal applies only to counter-driven slots.
      idx = (MSB_FIRST && !sel_mode) ? (3'd7 - slot) : slot;

      asm_nxt = asm_reg;
      if (d_valid)
         asm_nxt[idx] = d;

      if (sel_mode)
         complete = d_valid && (sel == 3'd7);
      else
         complete = d_valid && !sync && (cnt_eff == 3'd7);

      if (sel_mode)
         cnt_nxt = 3'd0;
      else if (sync)
         cnt_nxt = d_valid ? 3'd1 : 3'd0;
      else if (d_valid)
         cnt_nxt = cnt_eff + 3'd1;
      else
         cnt_nxt = cnt_eff;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_reg   <= 8'h00;
         cnt       <= 3'd0;
         prev_mode <= 1'b0;
         q         <= 8'h00;
         q_valid   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         asm_reg   <= asm_nxt;
         cnt       <= cnt_nxt;
         prev_mode <= sel_mode;
         if (complete) begin
            // A held, unconsumed frame wins; the new one is dropped.
            if (!q_valid || q_ready) begin
               q       <= asm_nxt;
               q_valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (q_valid && q_ready) begin
            q_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/demuxer8_tdm.md
DEMUXER8_TDM -- requirements
Module: demuxer8_tdm

Interface
REQ-001 SHALL provide parameter: MSB_FIRST, default 0, auto-mode bit order (0: first bit lands in q[0]; 1: first bit lands in q[7]).
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: d  input  1  serial data bit.
REQ-005 SHALL provide port: d_valid  input  1  d is sampled this cycle.
REQ-006 SHALL provide port: sync  input  1  frame start; forces slot counter to slot 0.
REQ-007 SHALL provide port: sel_mode  input  1  0 = auto (internal slot counter), 1 = addressed (slot taken from sel).
REQ-008 SHALL provide port: sel  input  3  target slot in addressed mode; ignored in auto mode.
REQ-009 SHALL provide port: q  output  8  assembled frame.
REQ-010 SHALL provide port: q_valid  output  1  q holds an unconsumed frame.
REQ-011 SHALL provide port: q_ready  input  1  consumer accepts q when q_valid && q_ready.
REQ-012 SHALL provide port: overflow  output  1  sticky, a completed frame was dropped.

Function
REQ-013 SHALL hold an 8-bit assembly register asm and a 3-bit slot counter cnt.
REQ-014 Auto mode, d_valid=1, sync=0: SHALL write d to asm[cnt] (asm[7-cnt] if MSB_FIRST=1) and increment cnt mod 8.
REQ-015 Auto mode: a write with cnt==7 SHALL complete a frame; cnt wraps to 0.
REQ-016 Addressed mode, d_valid=1: SHALL write d to asm[sel]; a write with sel==7 SHALL complete a frame; cnt held at 0.
REQ-017 d_valid=0: SHALL leave asm and cnt unchanged (idle gaps are allowed anywhere in a frame).
REQ-018 sync=1 with d_valid=1 (auto mode): SHALL write d to slot 0 and set cnt=1; the partial frame is discarded with no completion.
REQ-019 sync=1 with d_valid=0: SHALL set cnt=0.
REQ-020 sync SHALL have no effect in addressed mode.
REQ-021 A change of sel_mode between consecutive cycles SHALL set cnt=0; asm retained.
REQ-022 On completion, q SHALL load asm with the completing bit merged in, and q_valid SHALL assert on the same edge; q is visible the cycle after the 8th bit is sampled.
REQ-023 asm SHALL NOT be cleared on completion; unwritten slots of the next frame keep old values.
REQ-024 q_valid && q_ready with no completion: SHALL deassert q_valid on the next edge; q keeps its value.
REQ-025 Completion while q_valid=0, or q_valid && q_ready in the same cycle: SHALL load the new frame, q_valid=1, overflow unchanged.
REQ-026 Completion while q_valid && !q_ready: SHALL keep q unchanged, drop the new frame, and set overflow=1.
REQ-027 overflow SHALL stay set until reset.
REQ-028 q and q_valid SHALL be stable while q_valid && !q_ready.

Reset
REQ-029 rst=1 SHALL immediately, independent of clk, force q=8'h00, q_valid=0, overflow=0, asm=8'h00, cnt=0.
REQ-030 A frame in progress at reset SHALL be lost; the first d_valid after release is slot 0.

Verification
REQ-031 Auto, MSB_FIRST=0, q_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> q=8'h4D, q_valid high one cycle, overflow=0.
REQ-032 Same bits with random d_valid gaps -> q=8'h4D, q_valid only after the 8th valid bit.
REQ-033 3 bits, then sync with d=1, then 7 bits 0,0,0,0,0,0,1 -> single completion, q=8'h81; the 3 bits produce no frame.
REQ-034 q_ready=0, frame 8'h4D then frame 8'hFF -> q stays 8'h4D, q_valid=1, overflow=1; q_ready=1 for one cycle -> q_valid=0, overflow still 1.
REQ-035 Addressed mode, sel=0 d=1, then sel=7 d=1, starting from reset -> q=8'h81 one cycle after the sel=7 write; MSB_FIRST=1 in auto mode with bits 1,0,1,1,0,0,1,0 -> q=8'hB2.
REQ-036 rst pulse between clock edges after 4 bits -> q=0, q_valid=0, overflow=0 at once; next 8 bits yield a correct full frame.
